iic_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `iic_drv` EEPROM/IIC driver between two requesters. It accepts single-byte read/write commands and drives the driver's enable, address, direction and data inputs. It detects completion, enforces the EEPROM internal write-cycle delay after writes, and returns read data or a timeout error to the winning requester. It sits between application logic and `iic_drv`, clocked by the driver's `Scl4x` output.

---
 rtl/iic_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 13 +
 rtl/iic_arbiter.sv | 143 ++++++++++++++
 tb/tb_iic_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the iic_drv front end: arbiter states, direction
// constants and the driver clocking parameters reused by the top level.
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_WRWAIT,
    ST_RESP
  } arb_state_e;

  localparam logic IIC_RD = 1'b1;
  localparam logic IIC_WR = 1'b0;

  // iic_drv clocking: Scl4x runs at four times the SCL rate
  localparam int unsigned IIC_SYS_CLK_HZ = 50_000_000;
  localparam int unsigned IIC_SCL_HZ     = 250_000;
  localparam int unsigned IIC_SCL4X_HZ   = 4 * IIC_SCL_HZ;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/iic_arbiter.sv
// Shares one iic_drv between two requesters: round-robin grant, launch,
// completion/timeout detection and the EEPROM post-write idle period.
module iic_arbiter
  import iic_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter logic        BIT_SEL     = 1'b1,
  parameter int unsigned WR_WAIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_rh_wl,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_done,
  output logic        req0_err,
  output logic [7:0]  req0_rdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_rh_wl,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_done,
  output logic        req1_err,
  output logic [7:0]  req1_rdata,
  output logic        iic_en,
  output logic [6:0]  iic_slave_addr,
  output logic        iic_bit_sel,
  output logic        iic_rh_wl,
  output logic [15:0] iic_dev_addr,
  output logic [7:0]  iic_write_data,
  input  logic        iic_done,
  input  logic [7:0]  iic_read_data
);

  localparam int unsigned CW = cnt_width(WR_WAIT_CYC, TIMEOUT_CYC);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_WAIT_CYC - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  arb_state_e       state;
  logic             last_grant, owner, done_d, arb_last;
  logic [1:0]       req_v, gnt, ready_q, done_q, err_q;
  logic [1:0][7:0]  rdata_q;
  logic [CW-1:0]    to_cnt, wr_cnt;

  assign req_v = {req1_valid, req0_valid};
  // In RESP the owner becomes last_grant this edge, so arbitrate with it already
  assign arb_last = (state == ST_RESP) ? owner : last_grant;

  rr_arb2 u_arb (.req(req_v), .last_grant(arb_last), .gnt(gnt));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state          <= ST_IDLE;
      last_grant     <= 1'b1;
      owner          <= 1'b0;
      ready_q        <= '0;
      done_q         <= '0;
      err_q          <= '0;
      rdata_q        <= '0;
      iic_en         <= 1'b0;
      iic_rh_wl      <= 1'b0;
      iic_dev_addr   <= '0;
      iic_write_data <= '0;
      done_d         <= 1'b0;
      to_cnt         <= '0;
      wr_cnt         <= '0;
    end else begin
      done_d <= iic_done;
      case (state)
        ST_IDLE: begin
          if (|(req_v & ready_q)) begin
            owner          <= ready_q[1];
            iic_rh_wl      <= ready_q[1] ? req1_rh_wl : req0_rh_wl;
            iic_dev_addr   <= ready_q[1] ? req1_addr  : req0_addr;
            iic_write_data <= ready_q[1] ? req1_wdata : req0_wdata;
            ready_q        <= '0;
            iic_en         <= 1'b1;
            state          <= ST_LAUNCH;
          end else begin
            ready_q <= gnt;
          end
        end
        ST_LAUNCH: begin
          iic_en <= 1'b0;
          to_cnt <= '0;
          state  <= ST_BUSY;
        end
        ST_BUSY: begin
          // Only a 0->1 transition seen while busy counts as completion
          if (iic_done && !done_d) begin
            if (iic_rh_wl == IIC_RD) begin
              rdata_q[owner] <= iic_read_data;
              done_q[owner]  <= 1'b1;
              state          <= ST_RESP;
            end else begin
              wr_cnt <= '0;
              state  <= ST_WRWAIT;
            end
          end else if (to_cnt == TO_LAST) begin
            rdata_q[owner] <= 8'h00;
            done_q[owner]  <= 1'b1;
            err_q[owner]   <= 1'b1;
            state          <= ST_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_WRWAIT: begin
          if (wr_cnt == WR_LAST) begin
            done_q[owner] <= 1'b1;
            state         <= ST_RESP;
          end else begin
            wr_cnt <= wr_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          done_q     <= '0;
          err_q      <= '0;
          last_grant <= owner;
          ready_q    <= gnt;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready     = ready_q[0];
  assign req1_ready     = ready_q[1];
  assign req0_done      = done_q[0];
  assign req1_done      = done_q[1];
  assign req0_err       = err_q[0];
  assign req1_err       = err_q[1];
  assign req0_rdata     = rdata_q[0];
  assign req1_rdata     = rdata_q[1];
  assign iic_slave_addr = SLAVE_ADDR;
  assign iic_bit_sel    = BIT_SEL;

endmodule

// File: tb/tb_iic_arbiter.sv
// Randomized scoreboard bench for iic_arbiter with an EEPROM-style driver model.
module tb_iic_arbiter;

  localparam int WR_W = 50;
  localparam int TO   = 300;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic        vld [2];
  logic        rh  [2];
  logic [15:0] ad  [2];
  logic [7:0]  wd  [2];
  logic req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err;
  logic [7:0]  req0_rdata, req1_rdata;
  logic        iic_en, iic_bit_sel, iic_rh_wl;
  logic [6:0]  iic_slave_addr;
  logic [15:0] iic_dev_addr;
  logic [7:0]  iic_write_data;
  logic        iic_done = 1'b0;
  logic [7:0]  iic_read_data = 8'h00;

  int compared = 0, mismatched = 0, cyc = 0;

  typedef struct { int n; bit wr; bit err; logic [7:0] rdata; } exp_t;
  typedef struct { bit rh; logic [15:0] addr; logic [7:0] wdata; } cmd_t;
  exp_t exp_q[$];
  cmd_t cmd_q[$];
  int   grant_log[$];
  logic [7:0] ref_mem [logic [15:0]];
  logic [7:0] drv_mem [logic [15:0]];
  logic [7:0] ref_rd [2];
  int ref_last = 1;
  int force_lat = 0, en_cyc = 0, edge_cyc = 0;
  logic vld_prev [2];
  logic en_prev = 1'b0;

  iic_arbiter #(.SLAVE_ADDR(7'h50), .BIT_SEL(1'b1), .WR_WAIT_CYC(WR_W), .TIMEOUT_CYC(TO)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req0_valid(vld[0]), .req0_ready(req0_ready), .req0_rh_wl(rh[0]), .req0_addr(ad[0]),
    .req0_wdata(wd[0]), .req0_done(req0_done), .req0_err(req0_err), .req0_rdata(req0_rdata),
    .req1_valid(vld[1]), .req1_ready(req1_ready), .req1_rh_wl(rh[1]), .req1_addr(ad[1]),
    .req1_wdata(wd[1]), .req1_done(req1_done), .req1_err(req1_err), .req1_rdata(req1_rdata),
    .iic_en(iic_en), .iic_slave_addr(iic_slave_addr), .iic_bit_sel(iic_bit_sel),
    .iic_rh_wl(iic_rh_wl), .iic_dev_addr(iic_dev_addr), .iic_write_data(iic_write_data),
    .iic_done(iic_done), .iic_read_data(iic_read_data)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ 8'hB5;
  endfunction

  // Addresses in the top nibble F never get a driver response
  function automatic bit dead(input logic [15:0] a);
    return a[15:12] == 4'hF;
  endfunction

  function automatic logic rdy(input int n);
    return (n != 0) ? req1_ready : req0_ready;
  endfunction

  // Acceptance: expected responses derived from the command and a memory model
  always @(negedge Clk) begin : acc_mon
    exp_t e;
    cmd_t c;
    if (Rst_n) begin
      for (int n = 0; n < 2; n++) begin
        if (vld[n] && rdy(n)) begin
          chk("ready_onehot", rdy(1 - n), 1'b0);
          if (vld_prev[0] && vld_prev[1]) chk("fair_grant", n, 1 - ref_last);
          grant_log.push_back(n);
          c.rh = rh[n]; c.addr = ad[n]; c.wdata = wd[n];
          cmd_q.push_back(c);
          e.n = n; e.wr = !rh[n]; e.err = dead(ad[n]);
          if (e.err) begin
            e.rdata = 8'h00; ref_rd[n] = 8'h00;
          end else if (rh[n]) begin
            e.rdata = ref_mem.exists(ad[n]) ? ref_mem[ad[n]] : dflt(ad[n]);
            ref_rd[n] = e.rdata;
          end else begin
            ref_mem[ad[n]] = wd[n];
            e.rdata = ref_rd[n];
          end
          exp_q.push_back(e);
        end
      end
    end
    vld_prev[0] = vld[0];
    vld_prev[1] = vld[1];
  end

  always @(negedge Clk) begin : done_mon
    exp_t e;
    if (Rst_n) begin
      if (iic_en) chk("iic_en_width", en_prev, 1'b0);
      if (req0_done || req1_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {req1_done, req0_done}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("done_owner", {req1_done, req0_done}, (e.n != 0) ? 2'b10 : 2'b01);
          chk("err", (e.n != 0) ? req1_err : req0_err, e.err);
          chk("rdata", (e.n != 0) ? req1_rdata : req0_rdata, e.rdata);
          if (e.err)     chk("timeout_latency", cyc - en_cyc, TO + 1);
          else if (e.wr) chk("write_latency", cyc - edge_cyc, WR_W + 1);
          else           chk("read_latency", cyc - edge_cyc, 1);
          ref_last = e.n;
        end
      end
    end
    en_prev = iic_en;
  end

  // Driver model: holds iic_done high until two cycles after the next launch
  initial begin : drv
    bit pend;
    bit r;
    int cnt, drop;
    cmd_t c;
    logic [15:0] a;
    logic [7:0]  dw;
    pend = 0; cnt = 0; drop = 0; r = 0; a = '0; dw = '0;
    forever begin
      @(posedge Clk); #1;
      if (!Rst_n) begin
        pend = 0; drop = 0; iic_done = 1'b0;
      end else begin
        if (drop > 0) begin
          drop--;
          if (drop == 0) iic_done = 1'b0;
        end
        if (iic_en) begin
          en_cyc = cyc; a = iic_dev_addr; r = iic_rh_wl; dw = iic_write_data;
          if (cmd_q.size() == 0) begin
            chk("launch_unexpected", iic_en, 1'b0);
          end else begin
            c = cmd_q.pop_front();
            chk("launch_dir", r, c.rh);
            chk("launch_addr", a, c.addr);
            if (!c.rh) chk("launch_wdata", dw, c.wdata);
          end
          chk("slave_addr", iic_slave_addr, 7'h50);
          drop = 2;
          pend = !dead(a);
          cnt  = (force_lat > 0) ? force_lat : $urandom_range(4, 40);
        end else if (pend) begin
          cnt--;
          if (cnt == 0) begin
            if (r) iic_read_data = drv_mem.exists(a) ? drv_mem[a] : dflt(a);
            else   drv_mem[a] = dw;
            iic_done = 1'b1;
            edge_cyc = cyc;
            pend = 0;
          end
        end
      end
    end
  end

  task automatic issue(input int n, input bit r, input logic [15:0] a, input logic [7:0] d);
    bit ok = 0;
    @(posedge Clk); #1;
    vld[n] = 1'b1; rh[n] = r; ad[n] = a; wd[n] = d;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge Clk);
      if (rdy(n)) ok = 1;
    end
    if (!ok) chk("accept_timeout", rdy(n), 1'b1);
    @(posedge Clk); #1;
    vld[n] = 1'b0;
  endtask

  task automatic wait_drain();
    int i = 0;
    while ((exp_q.size() != 0 || vld[0] || vld[1]) && i < 20000) begin
      @(negedge Clk);
      i++;
    end
    if (i >= 20000) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge Clk);
  endtask

  function automatic logic [15:0] rnd_addr();
    if ($urandom_range(0, 7) == 0) return {4'hF, 12'($urandom)};
    return 16'($urandom_range(0, 15));
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_req0_done", req0_done, 1'b0);
    chk("rst_req1_done", req1_done, 1'b0);
    chk("rst_req0_err", req0_err, 1'b0);
    chk("rst_req1_err", req1_err, 1'b0);
    chk("rst_req0_rdata", req0_rdata, 8'h00);
    chk("rst_req1_rdata", req1_rdata, 8'h00);
    chk("rst_iic_en", iic_en, 1'b0);
    chk("rst_iic_rh_wl", iic_rh_wl, 1'b0);
    chk("rst_iic_dev_addr", iic_dev_addr, 16'h0000);
    chk("rst_iic_write_data", iic_write_data, 8'h00);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      vld[n] = 1'b0; rh[n] = 1'b0; ad[n] = '0; wd[n] = '0;
      vld_prev[n] = 1'b0; ref_rd[n] = 8'h00;
    end
    Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_reset_outputs();
    chk("rst_slave_addr", iic_slave_addr, 7'h50);
    chk("rst_bit_sel", iic_bit_sel, 1'b1);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("ready_no_valid", {req1_ready, req0_ready}, 2'b00);

    // Slow read, then write followed by a read-back of the same address
    force_lat = 200;
    issue(0, 1'b1, 16'h0010, 8'h00);
    wait_drain();
    force_lat = 0;
    chk("read_a5_held", req0_rdata, 8'hA5);
    issue(1, 1'b0, 16'h0020, 8'h3C);
    wait_drain();
    issue(1, 1'b1, 16'h0020, 8'h00);
    wait_drain();
    chk("readback_3c_held", req1_rdata, 8'h3C);

    // Both requesters continuously valid
    grant_log.delete();
    fork
      begin issue(0, 1'b1, 16'h0001, 8'h00); issue(0, 1'b0, 16'h0002, 8'h11); end
      begin issue(1, 1'b0, 16'h0003, 8'h22); issue(1, 1'b1, 16'h0002, 8'h00); end
    join
    wait_drain();
    chk("fair_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("fair_order", grant_log[i], i % 2);

    // Timeout, then the next command must still be accepted
    issue(0, 1'b1, 16'hF000, 8'h00);
    wait_drain();
    issue(0, 1'b1, 16'h0005, 8'h00);
    wait_drain();

    // Reset while busy: abandoned with no completion
    issue(0, 1'b1, 16'hF123, 8'h00);
    repeat (10) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    exp_q.delete();
    cmd_q.delete();
    ref_last = 1;
    ref_rd[0] = 8'h00;
    ref_rd[1] = 8'h00;
    repeat (2) @(negedge Clk);
    chk_reset_outputs();
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    issue(1, 1'b1, 16'h0030, 8'h00);
    wait_drain();

    // Random traffic from both requesters
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 15)) @(posedge Clk);
          issue(0, 1'($urandom), rnd_addr(), 8'($urandom));
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          repeat ($urandom_range(0, 15)) @(posedge Clk);
          issue(1, 1'($urandom), rnd_addr(), 8'($urandom));
        end
      end
    join
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
